mul_rr_scheduler: RTL and testbench

MUL_RR_SCHEDULER -- requirements
Module: mul_rr_scheduler

---
 rtl/mul_rr_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_mul_rr_scheduler.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_rr_scheduler.sv
// mul_rr_scheduler: round-robin issue of NUM_REQ operand streams onto one
// fixed-latency multiplier. A valid/id token shift register tracks in-flight
// ops. Results land in an in-order result FIFO that is protected by credits.
// Optional feature: define MUL_SCHED_PERF_CNT_EN to build the issue/stall
// counters; otherwise both counter outputs are tied to zero.
module mul_rr_scheduler #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DATA_LEN       = 32,
    parameter int unsigned PIPELINE_STAGE = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        flush,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_LEN-1:0] req_a,
    input  logic [NUM_REQ*DATA_LEN-1:0] req_b,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [DATA_LEN-1:0]         mul_a,
    output logic [DATA_LEN-1:0]         mul_b,
    input  logic [DATA_LEN-1:0]         mul_result,
    output logic                        rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
    output logic [DATA_LEN-1:0]         rsp_result,
    input  logic                        rsp_ready,
    output logic                        busy,
    output logic                        flush_done,
    output logic [31:0]                 issue_count,
    output logic [31:0]                 stall_count
);

    localparam int unsigned ID_W      = $clog2(NUM_REQ);
    localparam int unsigned BUF_DEPTH = PIPELINE_STAGE + 2;
    localparam int unsigned PTR_W     = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W     = $clog2(2 * BUF_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ID_W-1:0]       rr_ptr;
    logic                  grant_vld;
    logic [ID_W-1:0]       grant_id;
    logic                  can_issue;

    logic [PIPELINE_STAGE-1:0] sr_vld;
    logic [ID_W-1:0]           sr_id [PIPELINE_STAGE];

    logic [ID_W-1:0]       fifo_id   [BUF_DEPTH];
    logic [DATA_LEN-1:0]   fifo_data [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      fifo_cnt;
    logic [CNT_W-1:0]      inflight;
    logic [CNT_W-1:0]      total;
    logic                  push, pop;

    // Requester index k positions after the round-robin pointer.
    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base,
                                               input int unsigned k);
        return ID_W'((32'(base) + k) % NUM_REQ);
    endfunction

    // Circular FIFO pointer increment.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credits: in-flight tokens plus buffered results.
    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < PIPELINE_STAGE; i++)
            inflight = inflight + CNT_W'(sr_vld[i]);
    end

    assign total     = inflight + fifo_cnt;
    assign busy      = (total != '0);
    assign can_issue = (state_q == RUN) && enable && !flush && (total < CNT_W'(BUF_DEPTH));

    // Round-robin search from the pointer; one-hot ready.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!grant_vld && can_issue && req_valid[rr_idx(rr_ptr, k)]) begin
                grant_vld = 1'b1;
                grant_id  = rr_idx(rr_ptr, k);
            end
        end
        req_ready = '0;
        if (grant_vld)
            req_ready[grant_id] = 1'b1;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; flush_done marks the DRAIN->IDLE transition cycle.
    always_comb begin
        state_d    = state_q;
        flush_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (flush)       state_d = DRAIN;
                else if (enable) state_d = RUN;
            end
            RUN: begin
                if (flush)        state_d = DRAIN;
                else if (!enable) state_d = IDLE;
            end
            DRAIN: begin
                if (!busy) begin
                    state_d    = IDLE;
                    flush_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Round-robin pointer advances past the granted requester.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rr_ptr <= '0;
        else if (grant_vld)
            rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    end

    // Multiplier operand registers; hold when nothing is issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_a <= '0;
            mul_b <= '0;
        end else if (grant_vld) begin
            mul_a <= req_a[32'(grant_id) * DATA_LEN +: DATA_LEN];
            mul_b <= req_b[32'(grant_id) * DATA_LEN +: DATA_LEN];
        end
    end

    // Token shift register aligned with the multiplier latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_vld <= '0;
            for (int unsigned i = 0; i < PIPELINE_STAGE; i++)
                sr_id[i] <= '0;
        end else begin
            sr_vld[0] <= grant_vld;
            sr_id[0]  <= grant_id;
            for (int unsigned i = 1; i < PIPELINE_STAGE; i++) begin
                sr_vld[i] <= sr_vld[i-1];
                sr_id[i]  <= sr_id[i-1];
            end
        end
    end

    assign push       = sr_vld[PIPELINE_STAGE-1];
    assign rsp_valid  = (fifo_cnt != '0);
    assign pop        = rsp_valid && rsp_ready;
    assign rsp_id     = fifo_id[rd_ptr];
    assign rsp_result = fifo_data[rd_ptr];

    // Result FIFO: write on token exit, pop on consumer handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                fifo_id[i]   <= '0;
                fifo_data[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_id[wr_ptr]   <= sr_id[PIPELINE_STAGE-1];
                fifo_data[wr_ptr] <= mul_result;
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

`ifdef MUL_SCHED_PERF_CNT_EN
    logic stall_evt;
    assign stall_evt = (state_q == RUN) && (|req_valid) && !grant_vld;

    // Saturating performance counters, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_count <= '0;
            stall_count <= '0;
        end else begin
            if (grant_vld && (issue_count != '1))
                issue_count <= issue_count + 32'd1;
            if (stall_evt && (stall_count != '1))
                stall_count <= stall_count + 32'd1;
        end
    end
`else
    assign issue_count = '0;
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_mul_rr_scheduler.sv
// Bench for mul_rr_scheduler: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
`timescale 1ns/1ps
module tb_mul_rr_scheduler;

    localparam int unsigned NR = 4;
    localparam int unsigned DL = 32;
    localparam int unsigned PS = 2;
    localparam int unsigned BD = PS + 2;

    logic               clk = 1'b0;
    logic               reset, enable, flush, rsp_ready;
    logic [NR-1:0]      req_valid, req_ready;
    logic [NR*DL-1:0]   req_a, req_b;
    logic [DL-1:0]      mul_a, mul_b, mul_result, rsp_result, prod_q;
    logic               rsp_valid, busy, flush_done;
    logic [1:0]         rsp_id;
    logic [31:0]        issue_count, stall_count;

    int n_cmp = 0;
    int n_err = 0;

    mul_rr_scheduler #(.NUM_REQ(NR), .DATA_LEN(DL), .PIPELINE_STAGE(PS)) dut (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_ready(rsp_ready), .busy(busy), .flush_done(flush_done),
        .issue_count(issue_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Environment multiplier: result valid PS cycles after the grant edge.
    always @(posedge clk or posedge reset) begin
        if (reset) prod_q <= '0;
        else       prod_q <= mul_a * mul_b;
    end
    assign mul_result = prod_q;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int oh2i(input logic [NR-1:0] v);
        int r = -1;
        for (int i = 0; i < NR; i++)
            if (v[i]) r = (r == -1) ? i : -2;
        return r;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int          id;
        logic [DL-1:0] res;
        int          rem;
    } op_t;

    op_t         infl[$];
    op_t         rq[$];
    op_t         op;
    int          m_state;   // 0 idle, 1 run, 2 drain
    int          m_ptr;
    logic [DL-1:0] m_a, m_b;
    logic [31:0] m_issue, m_stall;
    int          g;
    logic [NR-1:0] e_ready;
    bit          e_busy;

    // Per-cycle compare against the model, then advance it across the next edge.
    always @(negedge clk) begin
        if (reset) begin
            infl.delete();
            rq.delete();
            m_state = 0; m_ptr = 0; m_a = '0; m_b = '0; m_issue = '0; m_stall = '0;
            chk("rst_req_ready",  64'(req_ready),   64'(0));
            chk("rst_rsp_valid",  64'(rsp_valid),   64'(0));
            chk("rst_busy",       64'(busy),        64'(0));
            chk("rst_flush_done", 64'(flush_done),  64'(0));
            chk("rst_mul_a",      64'(mul_a),       64'(0));
            chk("rst_mul_b",      64'(mul_b),       64'(0));
            chk("rst_issue",      64'(issue_count), 64'(0));
            chk("rst_stall",      64'(stall_count), 64'(0));
        end else begin
            e_busy = (infl.size() + rq.size()) > 0;
            g = -1;
            if (m_state == 1 && enable && !flush && (infl.size() + rq.size() < BD))
                for (int k = 0; k < NR; k++)
                    if (g < 0 && req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
            e_ready = '0;
            if (g >= 0) e_ready[g] = 1'b1;

            chk("req_ready",  64'(req_ready),  64'(e_ready));
            chk("rsp_valid",  64'(rsp_valid),  64'(rq.size() > 0));
            if (rq.size() > 0) begin
                chk("rsp_id",     64'(rsp_id),     64'(rq[0].id));
                chk("rsp_result", 64'(rsp_result), 64'(rq[0].res));
            end
            chk("busy",       64'(busy),       64'(e_busy));
            chk("flush_done", 64'(flush_done), 64'(m_state == 2 && !e_busy));
            chk("mul_a",      64'(mul_a),      64'(m_a));
            chk("mul_b",      64'(mul_b),      64'(m_b));
`ifdef MUL_SCHED_PERF_CNT_EN
            chk("issue_count", 64'(issue_count), 64'(m_issue));
            chk("stall_count", 64'(stall_count), 64'(m_stall));
`else
            chk("issue_count", 64'(issue_count), 64'(0));
            chk("stall_count", 64'(stall_count), 64'(0));
`endif
            // advance
            if (rq.size() > 0 && rsp_ready) void'(rq.pop_front());
            foreach (infl[i]) infl[i].rem--;
            while (infl.size() > 0 && infl[0].rem == 0) rq.push_back(infl.pop_front());
            if (g >= 0) begin
                op.id  = g;
                op.res = req_a[g*DL +: DL] * req_b[g*DL +: DL];
                op.rem = PS;
                infl.push_back(op);
                m_a = req_a[g*DL +: DL];
                m_b = req_b[g*DL +: DL];
                m_ptr = (g + 1) % NR;
                if (m_issue != '1) m_issue++;
            end else if (m_state == 1 && (|req_valid)) begin
                if (m_stall != '1) m_stall++;
            end
            case (m_state)
                0: if (flush) m_state = 2; else if (enable) m_state = 1;
                1: if (flush) m_state = 2; else if (!enable) m_state = 0;
                default: if (!e_busy) m_state = 0;
            endcase
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        bit done = 0;
        for (int n = 0; n < 30 && !done; n++) begin
            @(negedge clk);
            if (!busy) done = 1;
        end
        chk(name, 64'(busy), 64'(0));
        step();
    endtask

    int gseq[5];
    int exp_g[5]  = '{0, 1, 2, 3, 0};
    int rid[5];
    int exp_r4[4] = '{3, 0, 1, 2};
    int nr, lat, ng, ng2, npop, nfd;

    initial begin
        reset = 1'b1; enable = 1'b0; flush = 1'b0; rsp_ready = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0;
        for (int i = 0; i < NR; i++) begin
            req_a[i*DL +: DL] = DL'(i + 3);
            req_b[i*DL +: DL] = DL'(10 * i + 5);
        end
        repeat (2) step();
        reset = 1'b0;

        // All requesters valid: grants rotate 0,1,2,3,0.
        enable = 1'b1; rsp_ready = 1'b1;
        step();
        req_valid = '1;
        nr = 0;
        for (int c = 0; c < 14; c++) begin
            if (c == 5) req_valid = '0;
            @(negedge clk);
            if (c < 5) gseq[c] = oh2i(req_ready);
            if (rsp_valid) begin
                if (nr < 5) rid[nr] = int'(rsp_id);
                nr++;
            end
            step();
        end
        for (int c = 0; c < 5; c++) chk("rr_grant_seq", 64'(gseq[c]), 64'(exp_g[c]));
        chk("rr_rsp_count", 64'(nr), 64'(5));
        for (int c = 0; c < 5; c++) chk("rr_rsp_id_seq", 64'(rid[c]), 64'(exp_g[c]));

        // Requester 2 alone, 7*6.
        req_a[2*DL +: DL] = 32'd7;
        req_b[2*DL +: DL] = 32'd6;
        req_valid = 4'b0100;
        @(negedge clk);
        chk("solo_grant", 64'(req_ready), 64'(4'b0100));
        step();
        req_valid = '0;
        lat = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = k;
                chk("solo_rsp_id",     64'(rsp_id),     64'(2));
                chk("solo_rsp_result", 64'(rsp_result), 64'(42));
            end
        end
        chk("solo_latency", 64'(lat), 64'(3));
        step();

        // Consumer stalled: exactly BD grants, then resume in order.
        rsp_ready = 1'b0;
        req_valid = '1;
        ng = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (|req_ready) ng++;
            step();
        end
        chk("credit_grants", 64'(ng), 64'(4));
        rsp_ready = 1'b1;
        ng2 = 0; npop = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (|req_ready) ng2++;
            if (rsp_valid) begin
                if (npop < 4) rid[npop] = int'(rsp_id);
                npop++;
            end
            step();
        end
        for (int c = 0; c < 4; c++) chk("credit_rsp_order", 64'(rid[c]), 64'(exp_r4[c]));
        chk("credit_resume", 64'(ng2 > 0), 64'(1));
        req_valid = '0;
        wait_idle("credit_drain");

        // Flush with two ops in flight.
        req_valid = '1;
        step();
        step();
        flush = 1'b1; enable = 1'b0;
        @(negedge clk);
        chk("flush_cycle_grant", 64'(req_ready), 64'(0));
        step();
        flush = 1'b0;
        ng = 0; nfd = 0; npop = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (|req_ready) ng++;
            if (flush_done) nfd++;
            if (rsp_valid) npop++;
            step();
        end
        chk("flush_no_grants", 64'(ng), 64'(0));
        chk("flush_done_pulses", 64'(nfd), 64'(1));
        chk("flush_results", 64'(npop), 64'(2));
        chk("flush_not_busy", 64'(busy), 64'(0));
        req_valid = '0;

        // Reset with three buffered results.
        enable = 1'b1; rsp_ready = 1'b0;
        step();
        req_valid = '1;
        repeat (3) step();
        req_valid = '0;
        repeat (5) step();
        chk("pre_reset_buffered", 64'(rsp_valid), 64'(1));
        reset = 1'b1;
        #1;
        chk("reset_rsp_valid_now", 64'(rsp_valid),   64'(0));
        chk("reset_busy_now",      64'(busy),        64'(0));
        chk("reset_issue_now",     64'(issue_count), 64'(0));
        chk("reset_stall_now",     64'(stall_count), 64'(0));
        step();
        step();
        reset = 1'b0;
        rsp_ready = 1'b1;
        npop = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid) npop++;
            step();
        end
        chk("post_reset_no_rsp", 64'(npop), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
